accuracy_monitor: RTL and testbench
===================================

# accuracy_monitor

Synthesizable on-chip version of the training-accuracy bookkeeping for the DNN. It sits beside the output layer, watches the per-neuron output stream (one output neuron per clock), and classifies each training case as correct or incorrect. It keeps a sliding-window correct count, a running total, and case/epoch counters, so long MNIST runs can be monitored in FPGA without a simulator. Successor generalisations:
- Window depth, output-neuron count and epoch length are parameters.
- A selectable argmax scoring mode is added alongside exact-threshold scoring.

## Interface
- `n_out`, 16: output neurons streamed per training case.
- `width`, 32: bit width of `act_in` (two's complement fixed point).
- `window`, 1000: sliding-window depth in cases, ≥2.
- `cases_per_epoch`, 10000: cases per epoch, ≥1.
- `mode`, 0: 0 = exact threshold match on all neurons; 1 = argmax of `act_in` vs index of ideal one-hot.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `act_valid`  in  1  one output-neuron sample present this cycle.
- `act_in`  in  `width`  actual pre-threshold output, signed.
- `a_bit`  in  1  thresholded actual output bit for the sample.
- `y_in`  in  1  ideal output bit for the sample.
- `case_done`  in  1  one-cycle pulse closing the current case (cycle_clk).
- `result_valid`  out  1  one-cycle pulse; result outputs updated.
- `correct`  out  1  verdict of the last closed case.
- `recent`  out  `$clog2(window+1)`  correct count over the last `min(window, cases seen)` cases.
- `window_full`  out  1  at least `window` cases seen since reset.
- `total_correct`  out  32  correct cases since reset, saturating.
- `num_case`  out  32  cases closed since reset, saturating.
- `epoch`  out  16  completed epochs since reset, wraps.
- `epoch_done`  out  1  one-cycle pulse, coincident with `result_valid`, on the last case of an epoch.

## Operation
- Per-case accumulator state:
  - `idx`: sample count, saturates at `n_out`.
  - `mism`: any `a_bit != y_in`.
  - `max_val` and `max_idx`: strict `>` signed compare, so ties keep the lowest index. The first sample of a case loads unconditionally.
  - `ideal_idx` and `ideal_seen`: first sample with `y_in=1`.
- Samples arriving when `idx == n_out` are ignored, and `idx` stays `n_out`.
- Verdict at `case_done`:
  - mode 0: correct iff `idx == n_out` and not `mism`.
  - mode 1: correct iff `idx == n_out`, `ideal_seen`, and `max_idx == ideal_idx`.
  - Zero samples gives incorrect in both modes.
- If `act_valid` and `case_done` are asserted in the same cycle, that sample belongs to the closing case and is included in the verdict. The accumulator clears for the next case on the same edge.
- Sliding window:
  - A `window`-entry 1-bit history RAM/regfile with write pointer `wp`. `wp` wraps `window-1 -> 0`.
  - `recent_next = recent - old + new`, where `old` is the entry at `wp`. `old` is forced to 0 while `!window_full`, so the history needs no clearing at reset.
  - `window_full` sets when the fill counter reaches `window` and stays set.
- Epoch:
  - An internal case-in-epoch counter counts 0..`cases_per_epoch-1`.
  - On closing the case with count `cases_per_epoch-1`, the counter wraps to 0, `epoch` increments, and `epoch_done` pulses.
- FSM states:
  - IDLE: after reset, until the first sample.
  - ACCUM: samples seen.
  - EVAL: one cycle, result registration.
  - `case_done` in IDLE or ACCUM goes to EVAL. EVAL returns to ACCUM if a sample arrived in the EVAL cycle, otherwise to IDLE.
  - A sample arriving during EVAL counts toward the new case.
  - `case_done` during EVAL closes a zero-sample case (incorrect) and stays in EVAL.

## Timing
- `result_valid`, `correct`, `recent`, `total_correct`, `num_case`, `epoch` and `epoch_done` all update on the edge one cycle after the `case_done` edge (latency 1). Values hold until the next `result_valid`.
- Minimum spacing of `case_done` is 1 cycle; back-to-back pulses produce back-to-back results.
- Reset values: all outputs 0, including `correct`, `window_full` and `epoch`.
- State after reset: accumulator cleared, `wp=0`, fill counter 0, FSM in IDLE.
- Reset mid-case discards the partial case. Reset has priority over `case_done` in the same cycle, and no result is produced.
- `total_correct` and `num_case` saturate at 2^32-1. `epoch` wraps at 2^16.

## Test plan
- Mode 0, `n_out=16`, `window=4`: 6 cases with verdicts 1,1,0,1,1,1 → `recent` = 1,2,2,3,3,3. `window_full` rises on case 4. `total_correct`=5.
- Mode 0, one sample with `a_bit=1`, `y_in=0` at neuron 9 → `correct`=0; the identical case with the mismatch removed → `correct`=1.
- Mode 1:
  - `act_in` maximum at neuron 3 with ideal one-hot at 3 → correct.
  - Equal maxima at neurons 2 and 5 with ideal at 5 → incorrect (lowest-index tie).
  - Negative values -5,-2,-9 with ideal at 1 → correct.
- `cases_per_epoch=3`: 7 cases → `epoch_done` pulses on cases 3 and 6; `epoch`=2; `num_case`=7.
- Boundary cases:
  - `case_done` coincident with the 16th sample → counted, verdict valid.
  - 20 samples in one case → extra 4 ignored.
  - `case_done` with 0 samples → incorrect.
  - Reset asserted on sample 8 → no `result_valid`, all outputs 0 next cycle.

Source files
------------

// File: rtl/accuracy_monitor.sv
// accuracy_monitor: scores each streamed output-layer case as correct/incorrect and keeps
// sliding-window, running and epoch accuracy counters beside the DNN output layer.
//
// state | meaning
// IDLE  | no sample of the current case seen yet
// ACCUM | at least one sample of the current case accumulated
// EVAL  | verdict of the just-closed case being registered onto the outputs
module accuracy_monitor #(
    parameter int n_out           = 16,
    parameter int width           = 32,
    parameter int window          = 1000,
    parameter int cases_per_epoch = 10000,
    parameter int mode            = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         act_valid,
    input  logic [width-1:0]             act_in,
    input  logic                         a_bit,
    input  logic                         y_in,
    input  logic                         case_done,
    output logic                         result_valid,
    output logic                         correct,
    output logic [$clog2(window+1)-1:0]  recent,
    output logic                         window_full,
    output logic [31:0]                  total_correct,
    output logic [31:0]                  num_case,
    output logic [15:0]                  epoch,
    output logic                         epoch_done
);

    localparam int IW = $clog2(n_out + 1);
    localparam int RW = $clog2(window + 1);
    localparam int PW = $clog2(window);
    localparam int EW = $clog2(cases_per_epoch + 1);

    localparam logic [IW-1:0] N_FULL  = IW'(n_out);
    localparam logic [PW-1:0] WP_LAST = PW'(window - 1);
    localparam logic [EW-1:0] EP_LAST = EW'(cases_per_epoch - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EVAL  = 2'd2
    } state_t;

    state_t state, state_nx;
    logic   eval;

    logic [IW-1:0]    idx, m_idx;
    logic             mism, m_mism;
    logic [width-1:0] max_val, m_max_val;
    logic [IW-1:0]    max_idx, m_max_idx;
    logic [IW-1:0]    ideal_idx, m_ideal_idx;
    logic             ideal_seen, m_ideal_seen;
    logic             take;
    logic             verdict;
    logic             pend_correct;

    logic             hist [window];
    logic [PW-1:0]    wp;
    logic [EW-1:0]    ep_cnt;
    logic             old_bit;
    logic [RW-1:0]    recent_nx;

    // Accumulator as it stands including this cycle's sample, so a sample coincident
    // with case_done is scored with its own case.
    always_comb begin
        take         = act_valid && (idx != N_FULL);
        m_idx        = idx;
        m_mism       = mism;
        m_max_val    = max_val;
        m_max_idx    = max_idx;
        m_ideal_idx  = ideal_idx;
        m_ideal_seen = ideal_seen;
        if (take) begin
            m_idx  = idx + IW'(1);
            m_mism = mism | (a_bit ^ y_in);
            if ((idx == '0) || ($signed(act_in) > $signed(max_val))) begin
                m_max_val = act_in;
                m_max_idx = idx;
            end
            if (y_in && !ideal_seen) begin
                m_ideal_idx  = idx;
                m_ideal_seen = 1'b1;
            end
        end
    end

    always_comb begin
        verdict = 1'b0;
        if (mode == 0) begin
            verdict = (m_idx == N_FULL) && !m_mism;
        end else begin
            verdict = (m_idx == N_FULL) && m_ideal_seen && (m_max_idx == m_ideal_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || case_done) begin
            idx        <= '0;
            mism       <= 1'b0;
            max_val    <= '0;
            max_idx    <= '0;
            ideal_idx  <= '0;
            ideal_seen <= 1'b0;
        end else begin
            idx        <= m_idx;
            mism       <= m_mism;
            max_val    <= m_max_val;
            max_idx    <= m_max_idx;
            ideal_idx  <= m_ideal_idx;
            ideal_seen <= m_ideal_seen;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_correct <= 1'b0;
        end else if (case_done) begin
            pend_correct <= verdict;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        eval     = 1'b0;
        case (state)
            IDLE: begin
                if (case_done) begin
                    state_nx = EVAL;
                end else if (act_valid) begin
                    state_nx = ACCUM;
                end
            end
            ACCUM: begin
                if (case_done) begin
                    state_nx = EVAL;
                end
            end
            EVAL: begin
                eval = 1'b1;
                if (case_done) begin
                    state_nx = EVAL;
                end else if (act_valid) begin
                    state_nx = ACCUM;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // History is never cleared; entries are only trusted once every slot has been written.
    always_ff @(posedge clk) begin
        if (!reset && eval) begin
            hist[wp] <= pend_correct;
        end
    end

    always_comb begin
        old_bit   = window_full & hist[wp];
        recent_nx = recent - RW'(old_bit) + RW'(pend_correct);
    end

    // wp doubles as the fill counter: its first wrap marks the window as full.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_valid  <= 1'b0;
            correct       <= 1'b0;
            recent        <= '0;
            window_full   <= 1'b0;
            wp            <= '0;
            total_correct <= '0;
            num_case      <= '0;
            epoch         <= '0;
            epoch_done    <= 1'b0;
            ep_cnt        <= '0;
        end else begin
            result_valid <= eval;
            epoch_done   <= 1'b0;
            if (eval) begin
                correct <= pend_correct;
                recent  <= recent_nx;
                if (wp == WP_LAST) begin
                    wp          <= '0;
                    window_full <= 1'b1;
                end else begin
                    wp <= wp + PW'(1);
                end
                if (pend_correct && (total_correct != '1)) begin
                    total_correct <= total_correct + 32'd1;
                end
                if (num_case != '1) begin
                    num_case <= num_case + 32'd1;
                end
                if (ep_cnt == EP_LAST) begin
                    ep_cnt     <= '0;
                    epoch      <= epoch + 16'd1;
                    epoch_done <= 1'b1;
                end else begin
                    ep_cnt <= ep_cnt + EW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_accuracy_monitor.sv
// Bench for accuracy_monitor: a threshold-scoring and an argmax-scoring instance share one
// stimulus stream and are compared every cycle with a case-level reference model.
`timescale 1ns/1ps
module tb_accuracy_monitor;

    localparam int N_OUT = 16;
    localparam int WIN   = 4;
    localparam int CPE   = 3;
    localparam int RW    = $clog2(WIN + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, act_valid, a_bit, y_in, case_done;
    logic [31:0] act_in;

    logic          rv0, corr0, wfull0, edone0;
    logic          rv1, corr1, wfull1, edone1;
    logic [RW-1:0] rec0, rec1;
    logic [31:0]   tot0, tot1, ncase0, ncase1;
    logic [15:0]   ep0, ep1;

    accuracy_monitor #(.n_out(N_OUT), .width(32), .window(WIN), .cases_per_epoch(CPE), .mode(0)) dut0 (
        .clk(clk), .reset(reset), .act_valid(act_valid), .act_in(act_in), .a_bit(a_bit),
        .y_in(y_in), .case_done(case_done), .result_valid(rv0), .correct(corr0),
        .recent(rec0), .window_full(wfull0), .total_correct(tot0), .num_case(ncase0),
        .epoch(ep0), .epoch_done(edone0));

    accuracy_monitor #(.n_out(N_OUT), .width(32), .window(WIN), .cases_per_epoch(CPE), .mode(1)) dut1 (
        .clk(clk), .reset(reset), .act_valid(act_valid), .act_in(act_in), .a_bit(a_bit),
        .y_in(y_in), .case_done(case_done), .result_valid(rv1), .correct(corr1),
        .recent(rec1), .window_full(wfull1), .total_correct(tot1), .num_case(ncase1),
        .epoch(ep1), .epoch_done(edone1));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  q_val[$];
    bit  q_a[$];
    bit  q_y[$];
    bit  hq0[$];
    bit  hq1[$];
    bit  pend;
    bit  pend_v[2];
    int  n_cases;
    bit  started = 1'b0;
    bit  e_rv, e_full, e_edone;
    bit  e_corr[2];
    int  e_recent[2];
    int  e_total[2];
    int  e_num, e_epoch;

    function automatic bit score(input int m);
        int use_n;
        int ideal;
        int best;
        use_n = (q_val.size() > N_OUT) ? N_OUT : q_val.size();
        if (use_n < N_OUT) return 1'b0;
        if (m == 0) begin
            for (int i = 0; i < N_OUT; i++) if (q_a[i] != q_y[i]) return 1'b0;
            return 1'b1;
        end
        ideal = -1;
        for (int i = 0; i < N_OUT; i++) if (q_y[i] && ideal < 0) ideal = i;
        if (ideal < 0) return 1'b0;
        best = 0;
        for (int i = 1; i < N_OUT; i++) if (q_val[i] > q_val[best]) best = i;
        return best == ideal;
    endfunction

    function automatic int qsum(input bit q[$]);
        int s = 0;
        foreach (q[i]) s += int'(q[i]);
        return s;
    endfunction

    task automatic model_step();
        if (reset) begin
            q_val.delete(); q_a.delete(); q_y.delete();
            hq0.delete(); hq1.delete();
            pend = 1'b0; n_cases = 0;
            e_rv = 1'b0; e_full = 1'b0; e_edone = 1'b0; e_num = 0; e_epoch = 0;
            for (int m = 0; m < 2; m++) begin
                e_corr[m] = 1'b0; e_recent[m] = 0; e_total[m] = 0;
            end
        end else begin
            e_rv = 1'b0;
            e_edone = 1'b0;
            if (pend) begin
                n_cases++;
                e_rv    = 1'b1;
                e_num   = n_cases;
                e_epoch = (n_cases / CPE) % 65536;
                e_edone = (n_cases % CPE) == 0;
                e_full  = n_cases >= WIN;
                hq0.push_back(pend_v[0]);
                hq1.push_back(pend_v[1]);
                if (hq0.size() > WIN) void'(hq0.pop_front());
                if (hq1.size() > WIN) void'(hq1.pop_front());
                e_recent[0] = qsum(hq0);
                e_recent[1] = qsum(hq1);
                for (int m = 0; m < 2; m++) begin
                    e_corr[m]  = pend_v[m];
                    e_total[m] += int'(pend_v[m]);
                end
            end
            pend = 1'b0;
            if (act_valid) begin
                q_val.push_back(int'(act_in));
                q_a.push_back(a_bit);
                q_y.push_back(y_in);
            end
            if (case_done) begin
                pend_v[0] = score(0);
                pend_v[1] = score(1);
                pend = 1'b1;
                q_val.delete(); q_a.delete(); q_y.delete();
            end
        end
        started = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check_dut(input int d, input logic rv, input logic c, input logic [31:0] r,
                             input logic wf, input logic [31:0] t, input logic [31:0] n,
                             input logic [31:0] e, input logic ed);
        check($sformatf("d%0d.result_valid", d), {31'b0, rv}, {31'b0, e_rv});
        check($sformatf("d%0d.correct", d), {31'b0, c}, {31'b0, e_corr[d]});
        check($sformatf("d%0d.recent", d), r, 32'(e_recent[d]));
        check($sformatf("d%0d.window_full", d), {31'b0, wf}, {31'b0, e_full});
        check($sformatf("d%0d.total_correct", d), t, 32'(e_total[d]));
        check($sformatf("d%0d.num_case", d), n, 32'(e_num));
        check($sformatf("d%0d.epoch", d), e, 32'(e_epoch));
        check($sformatf("d%0d.epoch_done", d), {31'b0, ed}, {31'b0, e_edone});
    endtask

    initial forever begin
        @(negedge clk);
        if (started) begin
            check_dut(0, rv0, corr0, 32'(rec0), wfull0, tot0, ncase0, 32'(ep0), edone0);
            check_dut(1, rv1, corr1, 32'(rec1), wfull1, tot1, ncase1, 32'(ep1), edone1);
        end
    end

    // ---------------- stimulus ----------------
    int cv[32];
    bit ca[32];
    bit cy[32];

    task automatic drive(input bit v, input int val, input bit a, input bit y, input bit d);
        act_valid = v;
        act_in    = val;
        a_bit     = a;
        y_in      = y;
        case_done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        reset = 1'b0;
    endtask

    task automatic send_case(input int ns, input bit coinc);
        for (int i = 0; i < ns; i++)
            drive(1'b1, cv[i], ca[i], cy[i], coinc && (i == ns - 1));
        if (!coinc || ns == 0) drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    // Unique maximum at maxpos, ideal one-hot at ideal, thresholded bits matching.
    task automatic build(input int ideal, input int maxpos);
        for (int i = 0; i < 32; i++) begin
            cv[i] = -50;
            cy[i] = (i == ideal);
            ca[i] = (i == ideal);
        end
        cv[maxpos] = 100;
    endtask

    int exp_rec[7]  = '{1, 2, 2, 3, 3, 3, 4};
    bit exp_full[7] = '{0, 0, 0, 1, 1, 1, 1};
    bit exp_ed[7]   = '{0, 0, 1, 0, 0, 1, 0};
    bit win_v[7]    = '{1, 1, 0, 1, 1, 1, 1};

    initial begin
        int ns, ideal, gap;
        bit coinc;
        reset = 1'b1;
        act_valid = 1'b0; act_in = '0; a_bit = 1'b0; y_in = 1'b0; case_done = 1'b0;
        idle();
        idle();
        check("reset.num_case", ncase0, 32'd0);
        check("reset.recent", 32'(rec0), 32'd0);
        reset = 1'b0;

        // Window / epoch sequence, threshold scoring.
        for (int k = 0; k < 7; k++) begin
            build(k, k);
            if (!win_v[k]) ca[2] = ~ca[2];
            send_case(16, 1'b0);
            idle();
            check("win.result_valid", {31'b0, rv0}, 32'd1);
            check("win.correct", {31'b0, corr0}, {31'b0, win_v[k]});
            check("win.recent", 32'(rec0), 32'(exp_rec[k]));
            check("win.window_full", {31'b0, wfull0}, {31'b0, exp_full[k]});
            check("win.epoch_done", {31'b0, edone0}, {31'b0, exp_ed[k]});
            if (k == 5) check("win.total6", tot0, 32'd5);
        end
        check("win.total7", tot0, 32'd6);
        check("win.num_case", ncase0, 32'd7);
        check("win.epoch", 32'(ep0), 32'd2);

        // Single threshold mismatch at neuron 9, then the same case without it.
        build(4, 4);
        ca[9] = 1'b1;
        send_case(16, 1'b0); idle();
        check("mism9.correct", {31'b0, corr0}, 32'd0);
        ca[9] = 1'b0;
        send_case(16, 1'b0); idle();
        check("nomism.correct", {31'b0, corr0}, 32'd1);

        // Argmax scoring.
        build(3, 3);
        send_case(16, 1'b0); idle();
        check("argmax3.correct", {31'b0, corr1}, 32'd1);
        build(5, 2);
        cv[5] = 100;
        send_case(16, 1'b0); idle();
        check("tie25.correct", {31'b0, corr1}, 32'd0);
        build(1, 0);
        for (int i = 0; i < 32; i++) cv[i] = -100;
        cv[0] = -5; cv[1] = -2; cv[2] = -9;
        send_case(16, 1'b0); idle();
        check("neg.correct", {31'b0, corr1}, 32'd1);

        // Boundaries.
        build(7, 7);
        send_case(16, 1'b1); idle();
        check("coinc16.valid", {31'b0, rv0}, 32'd1);
        check("coinc16.correct0", {31'b0, corr0}, 32'd1);
        check("coinc16.correct1", {31'b0, corr1}, 32'd1);
        build(6, 6);
        for (int i = 16; i < 20; i++) begin
            ca[i] = 1'b1; cy[i] = 1'b0; cv[i] = 500;
        end
        send_case(20, 1'b0); idle();
        check("extra20.correct0", {31'b0, corr0}, 32'd1);
        check("extra20.correct1", {31'b0, corr1}, 32'd1);
        send_case(0, 1'b0); idle();
        check("zero.correct0", {31'b0, corr0}, 32'd0);
        check("zero.correct1", {31'b0, corr1}, 32'd0);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
        idle();

        build(8, 8);
        for (int i = 0; i < 7; i++) drive(1'b1, cv[i], ca[i], cy[i], 1'b0);
        reset = 1'b1;
        drive(1'b1, cv[7], ca[7], cy[7], 1'b0);
        reset = 1'b0;
        check("rst8.result_valid", {31'b0, rv0}, 32'd0);
        check("rst8.num_case", ncase0, 32'd0);
        check("rst8.total", tot0, 32'd0);
        check("rst8.epoch", 32'(ep0), 32'd0);
        check("rst8.window_full", {31'b0, wfull0}, 32'd0);
        idle();
        check("rst8.no_result", {31'b0, rv0}, 32'd0);
        for (int i = 0; i < 15; i++) drive(1'b1, cv[i], ca[i], cy[i], 1'b0);
        reset = 1'b1;
        drive(1'b1, cv[15], ca[15], cy[15], 1'b1);
        reset = 1'b0;
        idle();
        check("rstdone.no_result", {31'b0, rv0}, 32'd0);
        check("rstdone.num_case", ncase0, 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            ns    = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(0, 20));
            ideal = int'($urandom_range(0, 16));
            for (int i = 0; i < 32; i++) begin
                cv[i] = int'($urandom_range(0, 12)) - 6;
                cy[i] = (i == ideal);
                ca[i] = (i == ideal);
            end
            if (ideal < 16 && $urandom_range(0, 1) == 1) cv[ideal] = 7;
            if ($urandom_range(0, 4) == 0) ca[$urandom_range(0, 15)] ^= 1'b1;
            coinc = 1'($urandom_range(0, 1));
            for (int i = 0; i < ns; i++) begin
                if ($urandom_range(0, 9) == 0) idle();
                drive(1'b1, cv[i], ca[i], cy[i], coinc && (i == ns - 1));
            end
            if (!coinc || ns == 0) drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) idle();
            if ($urandom_range(0, 49) == 0) do_reset();
        end
        idle();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
